// File: rtl/rf_pkg.sv
// Shared types for the operand fetch unit and its register file.
package rf_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [AW-1:0]   reg_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_A,
        RD_B,
        RESP
    } ofu_state_t;

endpackage

// File: rtl/operand_fetch_unit_if.sv
// Decode-to-execute operand bus: request, response and write port.
interface operand_fetch_unit_if;
    import rf_pkg::*;

    logic      req_valid;
    logic      req_ready;
    reg_addr_t rs1;
    reg_addr_t rs2;
    logic      rsp_valid;
    logic      rsp_ready;
    word_t     rs1_data;
    word_t     rs2_data;
    logic      we;
    reg_addr_t rd;
    word_t     wd;
    logic      fetch;

    modport master (
        output req_valid, rs1, rs2, rsp_ready, we, rd, wd,
        input  req_ready, rsp_valid, rs1_data, rs2_data, fetch
    );

    modport slave (
        input  req_valid, rs1, rs2, rsp_ready, we, rd, wd,
        output req_ready, rsp_valid, rs1_data, rs2_data, fetch
    );

endinterface

// File: rtl/rf_storage.sv
// Integer register file: 1 combinational read, 1 synchronous write, x0 = 0.
module rf_storage
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  reg_addr_t raddr,
    output word_t     rdata,
    input  logic      we,
    input  reg_addr_t waddr,
    input  word_t     wdata
);

    word_t mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (raddr == '0) ? '0 : mem[raddr];

endmodule

// File: rtl/operand_fetch_unit.sv
// Two-phase operand fetch over a single RF read port.
// Define RF_WRITE_BYPASS_EN to forward a colliding write into the capture.
module operand_fetch_unit
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    operand_fetch_unit_if.slave bus
);

    ofu_state_t state, state_nx;
    reg_addr_t  rs1_q, rs2_q;
    word_t      op_a, op_b;
    reg_addr_t  raddr;
    word_t      rf_q, rd_val;
    logic       accept;

    rf_storage u_rf (
        .clk   (clk),
        .rst   (rst),
        .raddr (raddr),
        .rdata (rf_q),
        .we    (bus.we),
        .waddr (bus.rd),
        .wdata (bus.wd)
    );

    assign bus.fetch = (state == RD_A);
    assign raddr     = bus.fetch ? rs1_q : rs2_q;

`ifdef RF_WRITE_BYPASS_EN
    assign rd_val = (bus.we && bus.rd != '0 && bus.rd == raddr) ? bus.wd : rf_q;
`else
    assign rd_val = rf_q;
`endif

    always_comb begin
        state_nx      = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nx = RD_A;
            end
            RD_A: state_nx = RD_B;
            RD_B: state_nx = RESP;
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.req_ready = bus.rsp_ready;
                if (bus.rsp_ready) begin
                    state_nx = bus.req_valid ? RD_A : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rs1_q <= '0;
            rs2_q <= '0;
            op_a  <= '0;
            op_b  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rs1_q <= bus.rs1;
                rs2_q <= bus.rs2;
            end
            if (state == RD_A) op_a <= rd_val;
            if (state == RD_B) op_b <= rd_val;
        end
    end

    assign bus.rs1_data = op_a;
    assign bus.rs2_data = op_b;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Directed checks for operand_fetch_unit.
module tb_operand_fetch_unit;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    operand_fetch_unit_if bus ();

    operand_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.we = 1'b1;
        bus.rd = reg_addr_t'(a);
        bus.wd = d;
        step();
        bus.we = 1'b0;
    endtask

    // Issue a request from IDLE and advance to RESP.
    task automatic req(input int a, input int b);
        bus.req_valid = 1'b1;
        bus.rs1 = reg_addr_t'(a);
        bus.rs2 = reg_addr_t'(b);
        step();
        bus.req_valid = 1'b0;
        step();
        step();
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    logic [31:0] exp_b;

    initial begin
        bus.req_valid = 1'b0;
        bus.rs1 = '0;
        bus.rs2 = '0;
        bus.rsp_ready = 1'b0;
        bus.we = 1'b0;
        bus.rd = '0;
        bus.wd = '0;
        step();
        step();
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rs1_data", bus.rs1_data, 0);
        chk("rst_rs2_data", bus.rs2_data, 0);
        chk("rst_fetch", 32'(bus.fetch), 0);
        rst = 1'b0;
        step();

        // basic fetch and latency
        wr(5, 32'hDEADBEEF);
        wr(6, 32'h12345678);
        bus.req_valid = 1'b1;
        bus.rs1 = 5;
        bus.rs2 = 6;
        step();
        bus.req_valid = 1'b0;
        chk("rda_fetch", 32'(bus.fetch), 1);
        chk("rda_req_ready", 32'(bus.req_ready), 0);
        chk("rda_rsp_valid", 32'(bus.rsp_valid), 0);
        step();
        chk("rdb_fetch", 32'(bus.fetch), 0);
        chk("rdb_rsp_valid", 32'(bus.rsp_valid), 0);
        step();
        chk("resp_valid", 32'(bus.rsp_valid), 1);
        chk("resp_a", bus.rs1_data, 32'hDEADBEEF);
        chk("resp_b", bus.rs2_data, 32'h12345678);
        ack();
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("idle_req_ready", 32'(bus.req_ready), 1);

        // x0 stays zero
        wr(0, 32'hFFFFFFFF);
        req(0, 0);
        chk("x0_a", bus.rs1_data, 0);
        chk("x0_b", bus.rs2_data, 0);
        ack();

        // backpressure with a write to a captured register
        req(5, 6);
        for (int i = 0; i < 5; i++) begin
            bus.we = (i == 0);
            bus.rd = 5;
            bus.wd = 32'h1;
            step();
            bus.we = 1'b0;
            chk("hold_valid", 32'(bus.rsp_valid), 1);
            chk("hold_ready", 32'(bus.req_ready), 0);
            chk("hold_a", bus.rs1_data, 32'hDEADBEEF);
            chk("hold_b", bus.rs2_data, 32'h12345678);
        end
        ack();

        // write-read collision in RD_A
        wr(7, 32'hA);
        bus.req_valid = 1'b1;
        bus.rs1 = 7;
        bus.rs2 = 5;
        step();
        bus.req_valid = 1'b0;
        bus.we = 1'b1;
        bus.rd = 7;
        bus.wd = 32'hB;
        step();
        bus.we = 1'b0;
        step();
`ifdef RF_WRITE_BYPASS_EN
        chk("coll_a", bus.rs1_data, 32'hB);
`else
        chk("coll_a", bus.rs1_data, 32'hA);
`endif
        chk("coll_b", bus.rs2_data, 32'h1);
        ack();

        // back-to-back requests
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.rs1 = 6;
        bus.rs2 = 7;
        step();
        bus.rs1 = 5;
        bus.rs2 = 6;
        step();
        step();
        chk("b2b1_valid", 32'(bus.rsp_valid), 1);
        chk("b2b1_ready", 32'(bus.req_ready), 1);
        chk("b2b1_a", bus.rs1_data, 32'h12345678);
        chk("b2b1_b", bus.rs2_data, 32'hB);
        step();
        bus.req_valid = 1'b0;
        chk("b2b_no_idle", 32'(bus.fetch), 1);
        chk("b2b_gap", 32'(bus.rsp_valid), 0);
        step();
        step();
        chk("b2b2_valid", 32'(bus.rsp_valid), 1);
        chk("b2b2_a", bus.rs1_data, 32'h1);
        chk("b2b2_b", bus.rs2_data, 32'h12345678);
        step();
        bus.rsp_ready = 1'b0;
        chk("b2b_idle", 32'(bus.req_ready), 1);

        // reset during RD_B
        bus.req_valid = 1'b1;
        bus.rs1 = 5;
        bus.rs2 = 6;
        step();
        bus.req_valid = 1'b0;
        step();
        chk("pre_rst_rdb", 32'(bus.fetch), 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
        chk("mid_rst_ready", 32'(bus.req_ready), 1);
        chk("mid_rst_a", bus.rs1_data, 0);
        step();
        rst = 1'b0;
        step();
        req(5, 6);
        exp_b = 32'h0;
        chk("post_rst_a", bus.rs1_data, 0);
        chk("post_rst_b", bus.rs2_data, exp_b);
        ack();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
